// File: rtl/arm_mul_pkg.sv
// Shared encodings for the iterative multiplier: operation codes and FSM states.
package arm_mul_pkg;

    // Operation select as presented on MulOp; 2'b11 is reserved and behaves as MUL.
    localparam logic [1:0] MULOP_MUL   = 2'b00;
    localparam logic [1:0] MULOP_UMULL = 2'b01;
    localparam logic [1:0] MULOP_SMULL = 2'b10;

    // Controller states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL, UMULL and SMULL.
// The operation is started with a one-cycle start pulse and completes with a
// one-cycle done pulse WIDTH+2 cycles later. Results and flags are registered
// and only change when DONE is entered or on reset.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  IDLE   | waiting for start; operands, op and sign are latched on accept
//  RUN    | one multiplier bit per cycle, LSB first, WIDTH cycles
//  FIX    | negate the 2W-bit accumulator for a negative SMULL product
//  DONE   | done pulse; registered results become visible this cycle
module seq_mul_unit
    import arm_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [1:0]       op_q,     op_d;
    logic             neg_q,    neg_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [1:0]       flags_q,  flags_d;

    logic             is_smull;
    logic             is_long;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [PW-1:0]    acc_fixed;
    logic [PW-1:0]    partial;

    // Operand conditioning and result sign correction, shared by the FSM below.
    always_comb begin
        is_smull  = (MulOp == MULOP_SMULL);
        is_long   = (op_q == MULOP_UMULL) || (op_q == MULOP_SMULL);
        // Magnitude of the most negative value wraps back to itself, which is
        // exactly its unsigned magnitude.
        a_abs     = a[WIDTH-1] ? (~a + 1'b1) : a;
        b_abs     = b[WIDTH-1] ? (~b + 1'b1) : b;
        partial   = mplier_q[0] ? mcand_q : '0;
        // A zero accumulator negates to zero, so no negative zero can appear.
        acc_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    // Next-state and datapath update for the whole controller.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = MulOp;
                    acc_d = '0;
                    cnt_d = '0;
                    if (is_smull) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_abs};
                        mplier_d = b_abs;
                        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        neg_d    = 1'b0;
                    end
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Shift-register form of acc += mcand << cnt when bit cnt of b is set.
                acc_d    = acc_q + partial;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // Results are loaded here so they appear together with done.
                acc_d    = acc_fixed;
                res_lo_d = acc_fixed[WIDTH-1:0];
                if (is_long) begin
                    res_hi_d = acc_fixed[PW-1:WIDTH];
                    flags_d  = {acc_fixed[PW-1], (acc_fixed == '0)};
                end else begin
                    res_hi_d = '0;
                    flags_d  = {acc_fixed[WIDTH-1], (acc_fixed[WIDTH-1:0] == '0)};
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                // A start seen here is dropped; the next accept is in IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= MULOP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
        end
    end

    // Status decodes straight from state; results straight from their registers.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        ResultLo = res_lo_q;
        ResultHi = res_hi_q;
        MulFlags = flags_q;
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: directed corner cases, busy/reset
// behaviour and random operations checked against an arithmetic model.
module tb_seq_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  mul_op;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic [1:0]  mul_flags;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mul_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MulOp    (mul_op),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .ResultLo (res_lo),
        .ResultHi (res_hi),
        .MulFlags (mul_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full reference product for each operation, from plain integer arithmetic.
    function automatic logic [63:0] model_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b01:   p = ua * ub;
            2'b10: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
            end
            default: begin
                p = ua * ub;
                p = {32'b0, p[31:0]};
            end
        endcase
        return p;
    endfunction

    function automatic logic [1:0] model_flags(input logic [1:0] op, input logic [63:0] p);
        if (op == 2'b01 || op == 2'b10)
            return {p[63], (p == 64'd0)};
        return {p[31], (p[31:0] == 32'd0)};
    endfunction

    // Issue one op and return the number of cycles from the start cycle to done (-1 on timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; mul_op = op; a_i = a; b_i = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [63:0] p;
        p = model_prod(op, a, b);
        run_op(op, a, b, lat);
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " lo"}, {32'b0, res_lo}, {32'b0, p[31:0]});
        check({tag, " hi"}, {32'b0, res_hi}, {32'b0, p[63:32]});
        check({tag, " nz"}, {62'b0, mul_flags}, {62'b0, model_flags(op, p)});
    endtask

    initial begin
        int lat;
        int dones;
        logic [63:0] first_lo, first_hi;
        logic [1:0] op;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; mul_op = 2'b00; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        check("rst busy", {63'b0, busy}, 64'd0);
        check("rst done", {63'b0, done}, 64'd0);
        check("rst lo", {32'b0, res_lo}, 64'd0);
        check("rst hi", {32'b0, res_hi}, 64'd0);
        check("rst nz", {62'b0, mul_flags}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed expectations.
        @(negedge clk);
        start = 1'b1; mul_op = 2'b00; a_i = 32'd7; b_i = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("mul7x6 busy after accept", {63'b0, busy}, 64'd1);
        lat = 1;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("mul7x6 latency", 64'(lat), 64'd34);
        check("mul7x6 lo", {32'b0, res_lo}, 64'd42);
        check("mul7x6 hi", {32'b0, res_hi}, 64'd0);
        check("mul7x6 nz", {62'b0, mul_flags}, 64'd0);
        @(negedge clk);
        check("mul7x6 done width", {63'b0, done}, 64'd0);
        check("mul7x6 lo held", {32'b0, res_lo}, 64'd42);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("umull max lo", {32'b0, res_lo}, 64'h0000_0001);
        check("umull max hi", {32'b0, res_hi}, 64'hFFFF_FFFE);
        check("umull max nz", {62'b0, mul_flags}, 64'd2);

        run_op(2'b10, 32'hFFFF_FFFE, 32'd3, lat);
        check("smull -2x3 lo", {32'b0, res_lo}, 64'hFFFF_FFFA);
        check("smull -2x3 hi", {32'b0, res_hi}, 64'hFFFF_FFFF);
        check("smull -2x3 nz", {62'b0, mul_flags}, 64'd2);

        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, lat);
        check("smull min lo", {32'b0, res_lo}, 64'd0);
        check("smull min hi", {32'b0, res_hi}, 64'h4000_0000);
        check("smull min nz", {62'b0, mul_flags}, 64'd0);

        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, lat);
        check("mul wrap lo", {32'b0, res_lo}, 64'd0);
        check("mul wrap hi", {32'b0, res_hi}, 64'd0);
        check("mul wrap nz", {62'b0, mul_flags}, 64'd1);

        run_op(2'b10, 32'd0, 32'hFFFF_FFFB, lat);
        check("smull 0x-5 lo", {32'b0, res_lo}, 64'd0);
        check("smull 0x-5 hi", {32'b0, res_hi}, 64'd0);
        check("smull 0x-5 nz", {62'b0, mul_flags}, 64'd1);

        run_and_check("rsvd op", 2'b11, 32'h9000_0003, 32'h0000_0005);

        // Random operations against the model.
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'hFFFF_FFFF;
            run_and_check($sformatf("rand%0d op%0d", i, op), op, ra, rb);
        end

        // Start pulses while busy and in the DONE cycle must be ignored.
        first_lo = model_prod(2'b01, 32'd1234, 32'd5678);
        @(negedge clk);
        start = 1'b1; mul_op = 2'b01; a_i = 32'd1234; b_i = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        first_hi = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (done) begin
                dones++;
                if (dones == 1) begin
                    check("busy test done cycle", 64'(cyc), 64'd34);
                    first_hi = {res_hi, res_lo};
                end
            end
            if (cyc == 36) check("busy test idle after done", {63'b0, busy}, 64'd0);
            start  = (cyc == 5 || cyc == 10 || cyc == 33 || cyc == 34);
            mul_op = 2'b00; a_i = 32'd9; b_i = 32'd9;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy test done count", 64'(dones), 64'd1);
        check("busy test result", first_hi, first_lo);

        // Reset in the middle of RUN aborts, and start held during reset is not accepted.
        @(negedge clk);
        start = 1'b1; mul_op = 2'b10; a_i = 32'hFFFF_FFFE; b_i = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 15; cyc++) @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        check("mid reset busy", {63'b0, busy}, 64'd0);
        check("mid reset done", {63'b0, done}, 64'd0);
        check("mid reset lo", {32'b0, res_lo}, 64'd0);
        check("mid reset hi", {32'b0, res_hi}, 64'd0);
        check("mid reset nz", {62'b0, mul_flags}, 64'd0);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        check("post reset activity", 64'(dones), 64'd0);

        run_and_check("after reset mul", 2'b00, 32'd7, 32'd6);
        run_and_check("after reset smull", 2'b10, 32'h8000_0001, 32'h7FFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
